// File: rtl/ram_3.sv
// Byte-wide 1024-word scratch RAM with a per-word valid map.
// Locations that are unwritten, or cleared by reset, read back as zero.
module ram_3 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] data_out,
  input  logic [7:0] data_in,
  input  logic [9:0] address,
  input  logic       write,
  input  logic       select
);

  // No handshake: when select=1, one operation is accepted on every rising
  // clk edge (write=1 stores data_in, write=0 loads data_out). When select=0
  // the RAM is idle and address/data_in/write are ignored.

  logic [7:0] mem [0:1023];
  logic [1023:0] valid;

  logic do_write;
  logic do_read;

  assign do_write = select & write;
  assign do_read  = select & ~write;

  // Data array has no reset; the valid map masks stale contents. The rst term
  // keeps the array frozen while reset is held.
  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      mem[address] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (do_write) begin
      valid[address] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= 8'h00;
    end else if (do_read) begin
      data_out <= valid[address] ? mem[address] : 8'h00;
    end
  end

endmodule

// File: tb/tb_ram_3.sv
// Self-checking bench for ram_3: scenario tasks drive stimulus, push expected
// read data into exp_q, and compare it inline against data_out.
module tb_ram_3;

  logic       clk;
  logic       rst;
  logic [7:0] data_out;
  logic [7:0] data_in;
  logic [9:0] address;
  logic       write;
  logic       select;

  logic [7:0] exp_q[$];
  logic [7:0] exp;
  int         n_cmp;
  int         n_err;

  ram_3 dut (
    .clk      (clk),
    .rst      (rst),
    .data_out (data_out),
    .data_in  (data_in),
    .address  (address),
    .write    (write),
    .select   (select)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst     = 1'b1;
    select  = 1'b0;
    write   = 1'b0;
    address = '0;
    data_in = '0;
  end

  // drivers: inputs change on the falling edge, outputs sampled 1ns after rise
  task automatic drive_write(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    select  = 1'b1;
    write   = 1'b1;
    address = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_read(input logic [9:0] a);
    @(negedge clk);
    select  = 1'b1;
    write   = 1'b0;
    address = a;
    data_in = $urandom_range(0, 255);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    select  = 1'b0;
    write   = 1'b1;
    address = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp(output logic [7:0] e);
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: no expected value queued");
      e = 8'hxx;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_err++;
      $display("FAIL reset_time0: got %h want 00", data_out);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_err++;
      $display("FAIL reset_held: got %h want 00", data_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill;
    for (int k = 1; k <= 16; k++) drive_write(10'(k), 8'(k + 2));
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_err++;
      $display("FAIL write_holds_out: got %h want 00", data_out);
    end
    exp_q.push_back(8'd3);
    drive_read(10'd1);
    pop_exp(exp);
    n_cmp++;
    if (data_out !== exp) begin
      n_err++;
      $display("FAIL fill_read1: got %h want %h", data_out, exp);
    end
    exp_q.push_back(8'd7);
    drive_read(10'd5);
    pop_exp(exp);
    n_cmp++;
    if (data_out !== exp) begin
      n_err++;
      $display("FAIL fill_read5: got %h want %h", data_out, exp);
    end
    exp_q.push_back(8'd18);
    drive_read(10'd16);
    pop_exp(exp);
    n_cmp++;
    if (data_out !== exp) begin
      n_err++;
      $display("FAIL fill_read16: got %h want %h", data_out, exp);
    end
  endtask

  task automatic test_unwritten;
    logic [9:0] addrs [3];
    addrs = '{10'd0, 10'd17, 10'd1000};
    foreach (addrs[i]) begin
      exp_q.push_back(8'h00);
      drive_read(addrs[i]);
      pop_exp(exp);
      n_cmp++;
      if (data_out !== exp) begin
        n_err++;
        $display("FAIL unwritten_%0d: got %h want %h", addrs[i], data_out, exp);
      end
    end
  endtask

  task automatic test_random_reads;
    logic [9:0] a;
    for (int i = 0; i < 20; i++) begin
      a = 10'($urandom_range(0, 1023));
      exp_q.push_back((a >= 1 && a <= 16) ? 8'(a + 2) : 8'h00);
      drive_read(a);
      pop_exp(exp);
      n_cmp++;
      if (data_out !== exp) begin
        n_err++;
        $display("FAIL random_read_%0d: got %h want %h", a, data_out, exp);
      end
    end
  endtask

  task automatic test_deselect;
    exp_q.push_back(8'd18);
    drive_read(10'd16);
    pop_exp(exp);
    for (int i = 0; i < 4; i++) begin
      drive_idle(10'd5, 8'hFF);
      n_cmp++;
      if (data_out !== exp) begin
        n_err++;
        $display("FAIL deselect_hold_%0d: got %h want %h", i, data_out, exp);
      end
    end
    exp_q.push_back(8'd7);
    drive_read(10'd5);
    pop_exp(exp);
    n_cmp++;
    if (data_out !== exp) begin
      n_err++;
      $display("FAIL deselect_read5: got %h want %h", data_out, exp);
    end
  endtask

  task automatic test_boundaries;
    drive_write(10'd1023, 8'hAB);
    drive_write(10'd0, 8'h5C);
    exp_q.push_back(8'hAB);
    exp_q.push_back(8'h5C);
    drive_read(10'd1023);
    pop_exp(exp);
    n_cmp++;
    if (data_out !== exp) begin
      n_err++;
      $display("FAIL bound_read1023: got %h want %h", data_out, exp);
    end
    drive_read(10'd0);
    pop_exp(exp);
    n_cmp++;
    if (data_out !== exp) begin
      n_err++;
      $display("FAIL bound_read0: got %h want %h", data_out, exp);
    end
  endtask

  task automatic test_back_to_back;
    drive_write(10'd5, 8'h11);
    exp_q.push_back(8'h11);
    drive_read(10'd5);
    pop_exp(exp);
    n_cmp++;
    if (data_out !== exp) begin
      n_err++;
      $display("FAIL overwrite_read5: got %h want %h", data_out, exp);
    end
  endtask

  task automatic test_reset_mid;
    exp_q.push_back(8'd4);
    drive_read(10'd2);
    pop_exp(exp);
    n_cmp++;
    if (data_out !== exp) begin
      n_err++;
      $display("FAIL stream_read2: got %h want %h", data_out, exp);
    end
    exp_q.push_back(8'd5);
    drive_read(10'd3);
    pop_exp(exp);
    n_cmp++;
    if (data_out !== exp) begin
      n_err++;
      $display("FAIL stream_read3: got %h want %h", data_out, exp);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_err++;
      $display("FAIL async_reset: got %h want 00", data_out);
    end
    #1 rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      logic [9:0] a;
      a = (k == 17) ? 10'd1023 : 10'(k);
      exp_q.push_back(8'h00);
      drive_read(a);
      pop_exp(exp);
      n_cmp++;
      if (data_out !== exp) begin
        n_err++;
        $display("FAIL post_reset_read_%0d: got %h want %h", a, data_out, exp);
      end
    end
    drive_write(10'd3, 8'h42);
    exp_q.push_back(8'h42);
    drive_read(10'd3);
    pop_exp(exp);
    n_cmp++;
    if (data_out !== exp) begin
      n_err++;
      $display("FAIL post_reset_write3: got %h want %h", data_out, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill();
    test_unwritten();
    test_random_reads();
    test_deselect();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_3.md
# ram_3

Single-port 1024 x 8 synchronous RAM with chip select and a per-word valid map. Acts as the general-purpose byte-wide scratch memory of the datapath. Writes and reads are both clocked. An asynchronous reset invalidates every word, so unwritten or reset locations read back as zero.

## Interface
- No parameters. Depth is fixed at 1024 words and width at 8 bits.
- clk  input  1  rising-edge clock for all storage.
- rst  input  1  asynchronous, active-high reset.
- data_out  output  8  registered read data.
- data_in  input  8  write data.
- address  input  10  word address, 0..1023, no wrap or aliasing.
- write  input  1  1 = write cycle, 0 = read cycle. Qualified by select.
- select  input  1  chip select, active high. When 0 the RAM is idle.

## Operation
- Storage: mem[0..1023] of 8 bits each, plus valid[0..1023] of 1 bit each.
- Write happens on a rising clk edge when select=1 and write=1:
  - mem[address] <= data_in
  - valid[address] <= 1
  - data_out holds its previous value.
- Read happens on a rising clk edge when select=1 and write=0:
  - data_out <= valid[address] ? mem[address] : 8'h00.
- Idle happens on a rising clk edge when select=0:
  - no change to mem, valid, or data_out.
  - address, data_in and write are don't-care.
- Reset (rst=1) takes effect immediately, without waiting for clk:
  - all valid bits cleared to 0.
  - data_out cleared to 8'h00.
  - mem contents need not be cleared; the valid map masks them.
- While rst=1, all clocked operations are ignored.
- After rst falls, the first rising edge with select=1 operates normally.
- A write followed by a read of the same address on the next edge returns the new data.
- Rewriting a valid word overwrites it. valid stays 1.
- No handshake and no busy state. One operation is accepted every cycle.

## Timing
- Write latency: data is stored at the edge where it is sampled, and is readable from the next edge onward.
- Read latency: 1 cycle. address is sampled at edge N; data_out is valid after edge N and holds until the next read edge or reset.
- Inputs must meet setup and hold to clk. There is no combinational path from inputs to data_out.
- Reset: asynchronous assert with immediate effect on data_out and valid. Deassertion is synchronized externally by the integrator.
- Reset is 1 and data_out is 8'h00 from time 0 until the first read after reset.

## Test plan
- Fill and read back:
  - Assert then release reset.
  - Write data_in=k+2 to address=k for k=1..16 (select=1, write=1).
  - Read addresses 1, 5 and 16 → data_out = 3, 7 and 18 one cycle after each address is sampled.
- Unwritten locations: after the fill, read address 0, then 17, then 1000 → data_out = 0 each time.
- Deselect:
  - With select=0 and write=1, present data_in=8'hFF at address 5 for several cycles.
  - Read 5 → 7. data_out does not change while select=0.
- Boundaries and overwrite:
  - Write 8'hAB to 1023 and 8'h5C to 0. Read 1023 → 8'hAB; read 0 → 8'h5C.
  - Write 8'h11 to 5, then read 5 → 8'h11.
- Reset mid-operation:
  - Pulse rst between clock edges during a read stream. data_out goes to 0 immediately, before the next edge.
  - Subsequent reads of 1..16 and 1023 → 0.
  - A new write of 8'h42 to 3, then read 3 → 8'h42.
- Random reads: 20 reads at uniformly random 10-bit addresses after the fill. Each data_out equals k+2 for addresses 1..16, and 0 elsewhere.
